gpio_ctrl: RTL and testbench

Memory-mapped controller for the SoC's LED and push-button resource. It owns the 9 LED outputs and the 8 button inputs. It exposes four word registers to the CPU data bus through a req/ready handshake. Button inputs are synchronised and debounced, rising edges are latched as events, and a maskable level interrupt is raised to the CPU.

---
 rtl/gpio_ctrl_pkg.sv | 19 +
 rtl/gpio_ctrl_if.sv | 20 ++
 rtl/gpio_ctrl_debounce.sv | 48 ++++
 rtl/gpio_ctrl.sv | 92 +++++++++
 tb/tb_gpio_ctrl.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/gpio_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gpio_ctrl_pkg : register map and bus FSM encoding for gpio_ctrl      |
// | Revision      : 1.0                                                  |
// +----------------------------------------------------------------------+
package gpio_ctrl_pkg;

  typedef logic [1:0] gpio_addr_t;

  localparam gpio_addr_t GPIO_LED       = 2'd0;
  localparam gpio_addr_t GPIO_BTN_STATE = 2'd1;
  localparam gpio_addr_t GPIO_BTN_EVENT = 2'd2;
  localparam gpio_addr_t GPIO_IRQ_EN    = 2'd3;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_ACK  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/gpio_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gpio_ctrl_if : req/ready register bus between CPU and gpio_ctrl      |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
interface gpio_ctrl_if;
  import gpio_ctrl_pkg::*;

  logic        req;
  logic        we;
  gpio_addr_t  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;

  modport master (output req, we, addr, wdata, input rdata, ready);
  modport slave  (input req, we, addr, wdata, output rdata, ready);

endinterface
`default_nettype wire

// File: rtl/gpio_ctrl_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | debounce : 2-flop synchroniser plus counter debouncer, one bit       |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic i_btn,
  output logic      o_stable,
  output logic      o_rise
);

  logic [1:0] r_sync;
  logic       r_stable;
  logic [7:0] r_cnt;
  logic       w_diff;
  logic       w_accept;

  assign w_diff   = (r_sync[1] != r_stable);
  assign w_accept = w_diff && (r_cnt == 8'(DEBOUNCE_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync   <= '0;
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_sync <= {r_sync[0], i_btn};
      if (w_accept) begin
        r_stable <= r_sync[1];
        r_cnt    <= '0;
      end else if (w_diff) begin
        r_cnt <= r_cnt + 8'd1;
      end else begin
        r_cnt <= '0;
      end
    end
  end

  // Pulse is combinational so the event register sets on the same edge as stable
  assign o_stable = r_stable;
  assign o_rise   = w_accept & r_sync[1];

endmodule
`default_nettype wire

// File: rtl/gpio_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gpio_ctrl : LED / push-button controller with W1C events and irq     |
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
module gpio_ctrl
  import gpio_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int LED_W           = 9,
  parameter int BTN_W           = 8
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  gpio_ctrl_if.slave            bus,
  output logic [LED_W-1:0]      leds,
  input  wire logic [BTN_W-1:0] buttons,
  output logic                  irq
);

  logic [0:0]       r_state;
  logic [LED_W-1:0] r_led;
  logic [BTN_W-1:0] r_evt;
  logic [BTN_W-1:0] r_irq_en;

  logic [BTN_W-1:0] w_stable;
  logic [BTN_W-1:0] w_rise;
  logic [BTN_W-1:0] w_clr;
  logic             w_ack;
  logic             w_wr;
  logic [31:0]      w_rdata;

  for (genvar gi = 0; gi < BTN_W; gi++) begin : g_btn
    debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_btn    (buttons[gi]),
      .o_stable (w_stable[gi]),
      .o_rise   (w_rise[gi])
    );
  end

  assign w_ack = (r_state == ST_ACK);
  assign w_wr  = w_ack & bus.we;
  assign w_clr = (w_wr && bus.addr == GPIO_BTN_EVENT) ? bus.wdata[BTN_W-1:0] : '0;

  // ACK always lasts one cycle regardless of req, so a dropped req cannot abort it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (bus.req) r_state <= ST_ACK;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_led    <= '0;
      r_irq_en <= '0;
      r_evt    <= '0;
    end else begin
      if (w_wr && bus.addr == GPIO_LED)    r_led    <= bus.wdata[LED_W-1:0];
      if (w_wr && bus.addr == GPIO_IRQ_EN) r_irq_en <= bus.wdata[BTN_W-1:0];
      // A rise arriving with a clear of the same bit keeps the bit set
      r_evt <= (r_evt & ~w_clr) | w_rise;
    end
  end

  always_comb begin
    w_rdata = '0;
    if (w_ack) begin
      case (bus.addr)
        GPIO_LED:       w_rdata[LED_W-1:0] = r_led;
        GPIO_BTN_STATE: w_rdata[BTN_W-1:0] = w_stable;
        GPIO_BTN_EVENT: w_rdata[BTN_W-1:0] = r_evt;
        default:        w_rdata[BTN_W-1:0] = r_irq_en;
      endcase
    end
  end

  assign bus.ready = w_ack;
  assign bus.rdata = w_rdata;
  assign leds      = r_led;
  assign irq       = |(r_evt & r_irq_en);

endmodule
`default_nettype wire

// File: tb/tb_gpio_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_gpio_ctrl : directed bench with a per-cycle reference model       |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
module tb_gpio_ctrl;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [8:0] leds;
  logic [7:0] buttons = '0;
  logic       irq;

  int n_cmp = 0;
  int n_err = 0;

  gpio_ctrl_if bus ();

  gpio_ctrl #(
    .DEBOUNCE_CYCLES (D),
    .LED_W           (9),
    .BTN_W           (8)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .leds    (leds),
    .buttons (buttons),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  // Reference model: register contents plus a history of raw button samples
  logic [8:0] m_led = '0;
  logic [7:0] m_stable = '0;
  logic [7:0] m_evt = '0;
  logic [7:0] m_en = '0;
  logic       m_ack = 1'b0;
  logic [7:0] raw_hist [0:D];
  logic [7:0] m_rise;
  logic [7:0] m_next;
  logic [7:0] m_clr;
  logic       all_diff;

  initial for (int j = 0; j <= D; j++) raw_hist[j] = '0;

  function automatic logic [31:0] m_sel(input logic [1:0] a);
    case (a)
      2'd0:    return {23'd0, m_led};
      2'd1:    return {24'd0, m_stable};
      2'd2:    return {24'd0, m_evt};
      default: return {24'd0, m_en};
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_led = '0; m_stable = '0; m_evt = '0; m_en = '0; m_ack = 1'b0;
      for (int j = 0; j <= D; j++) raw_hist[j] = '0;
    end else begin
      // Stable level flips once the last D synchronised samples all disagree with it
      m_rise = '0;
      m_next = m_stable;
      for (int b = 0; b < 8; b++) begin
        all_diff = 1'b1;
        for (int j = 1; j <= D; j++)
          if (raw_hist[j][b] == m_stable[b]) all_diff = 1'b0;
        if (all_diff) begin
          m_next[b] = ~m_stable[b];
          if (!m_stable[b]) m_rise[b] = 1'b1;
        end
      end
      m_clr = '0;
      if (m_ack) begin
        if (bus.we) begin
          case (bus.addr)
            2'd0:    m_led = bus.wdata[8:0];
            2'd2:    m_clr = bus.wdata[7:0];
            2'd3:    m_en  = bus.wdata[7:0];
            default: ;
          endcase
        end
        m_ack = 1'b0;
      end else if (bus.req) begin
        m_ack = 1'b1;
      end
      m_evt    = (m_evt & ~m_clr) | m_rise;
      m_stable = m_next;
      for (int j = D; j > 0; j--) raw_hist[j] = raw_hist[j-1];
      raw_hist[0] = buttons;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model_ready", {31'd0, bus.ready}, {31'd0, m_ack});
    chk("model_rdata", bus.rdata, m_ack ? m_sel(bus.addr) : 32'd0);
    chk("model_leds", {23'd0, leds}, {23'd0, m_led});
    chk("model_irq", {31'd0, irq}, {31'd0, |(m_evt & m_en)});
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_rd(input logic [1:0] a, input logic [31:0] exp, input string name);
    bus.req = 1'b1; bus.we = 1'b0; bus.addr = a; bus.wdata = '0;
    #1 chk({name, "_idle_ready"}, {31'd0, bus.ready}, 32'd0);
    @(posedge clk); #1;
    chk({name, "_ready"}, {31'd0, bus.ready}, 32'd1);
    chk(name, bus.rdata, exp);
    bus.req = 1'b0;
    @(posedge clk); #1;
    chk({name, "_ready_drop"}, {31'd0, bus.ready}, 32'd0);
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    bus.req = 1'b1; bus.we = 1'b1; bus.addr = a; bus.wdata = d;
    @(posedge clk); #1;
    chk("wr_ready", {31'd0, bus.ready}, 32'd1);
    bus.req = 1'b0;
    @(posedge clk); #1;
    bus.we = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_leds", {23'd0, leds}, 32'd0);
    chk("rst_ready", {31'd0, bus.ready}, 32'd0);
    chk("rst_rdata", bus.rdata, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    tick(3);
    rst_n = 1'b1;
    tick(1);
    bus_rd(2'd1, 32'd0, "btn_state_reset");

    bus_wr(2'd0, 32'h1A5);
    chk("led_after_wr", {23'd0, leds}, 32'h1A5);
    bus_rd(2'd0, 32'h1A5, "led_rd_1a5");
    bus_wr(2'd0, 32'hFFFF_FFFF);
    chk("led_after_wr_ff", {23'd0, leds}, 32'h1FF);
    bus_rd(2'd0, 32'h1FF, "led_rd_1ff");
    bus_wr(2'd1, 32'hFF);
    bus_rd(2'd1, 32'd0, "btn_state_ro");

    // Glitch of 3 cycles on button 2 must vanish
    buttons[2] = 1'b1;
    tick(3);
    buttons[2] = 1'b0;
    tick(10);
    bus_rd(2'd1, 32'd0, "glitch_state");
    bus_rd(2'd2, 32'd0, "glitch_event");

    bus_wr(2'd3, 32'h04);
    buttons[2] = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick(1);
      chk($sformatf("irq_edge_k+%0d", i), {31'd0, irq}, (i >= 5) ? 32'd1 : 32'd0);
    end
    bus_rd(2'd1, 32'h04, "hold_state");
    bus_rd(2'd2, 32'h04, "hold_event");
    chk("irq_pending", {31'd0, irq}, 32'd1);

    bus_wr(2'd2, 32'h04);
    chk("irq_after_w1c", {31'd0, irq}, 32'd0);
    bus_rd(2'd2, 32'd0, "event_cleared");

    bus_wr(2'd3, 32'h00);
    buttons[2] = 1'b0;
    tick(8);
    buttons[2] = 1'b1;
    tick(8);
    chk("irq_masked", {31'd0, irq}, 32'd0);
    bus_rd(2'd2, 32'h04, "event_masked_latched");

    // Clear of bit 5 commits on the edge its stable level rises
    buttons[5] = 1'b1;
    tick(4);
    bus_wr(2'd2, 32'h20);
    bus_rd(2'd2, 32'h24, "w1c_collision");

    buttons = '0;
    tick(8);
    bus.req = 1'b1; bus.we = 1'b1; bus.addr = 2'd0; bus.wdata = 32'h0FF;
    @(posedge clk); #1;
    chk("midwr_ready_ack", {31'd0, bus.ready}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("midwr_ready", {31'd0, bus.ready}, 32'd0);
    chk("midwr_leds", {23'd0, leds}, 32'd0);
    chk("midwr_rdata", bus.rdata, 32'd0);
    bus.req = 1'b0; bus.we = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    bus_rd(2'd0, 32'd0, "led_after_reset");
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
